// File: rtl/sprite_mem_server.sv
// sprite_mem_server: memory-side responder for the sprite pixel loader.
// Turns each rising edge of the MEM_CLK strobe into two 24-bit ROM reads and
// returns the pair as one 48-bit two-pixel word on DATA_OUT.
// Optional feature: define SPRITE_SERVER_CACHE_EN to add a one-entry word cache
// that answers a repeated {MEM_SEL, MEM_ADDR} request without touching the ROM.
module sprite_mem_server #(
    parameter int unsigned ROM_AW      = 19,
    parameter int unsigned ROM_LAT     = 1,
    parameter int unsigned BG_BASE     = 0,
    parameter int unsigned PWR_BASE    = 64800,
    parameter int unsigned RED_BASE    = 65000,
    parameter int unsigned GREEN_BASE  = 79112,
    parameter int unsigned BLUE_BASE   = 93224,
    parameter int unsigned YELLOW_BASE = 107336,
    parameter int unsigned WIN_BASE    = 121448,
    parameter int unsigned LOSE_BASE   = 143048
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MEM_CLK,
    input  logic [15:0]       MEM_ADDR,
    input  logic [2:0]        MEM_SEL,
    output logic [47:0]       DATA_OUT,
    output logic              DATA_VALID,
    output logic              BUSY,
    output logic              ADDR_ERR,
    output logic              OVERRUN,
    output logic              ROM_RD,
    output logic [ROM_AW-1:0] ROM_ADDR,
    input  logic [23:0]       ROM_DATA
);

    // Sprite sizes in 48-bit words; an address at or above these is rejected.
    localparam int unsigned BG_LIMIT     = 64800;
    localparam int unsigned PWR_LIMIT    = 200;
    localparam int unsigned RED_LIMIT    = 14112;
    localparam int unsigned GREEN_LIMIT  = 14112;
    localparam int unsigned BLUE_LIMIT   = 14112;
    localparam int unsigned YELLOW_LIMIT = 14112;
    localparam int unsigned WIN_LIMIT    = 21600;
    localparam int unsigned LOSE_LIMIT   = 25200;

    // Last wait-state count before ROM_DATA is valid.
    localparam logic [2:0] LatLast = 3'(ROM_LAT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdHi,
        StWtHi,
        StRdLo,
        StWtLo,
        StDone,
        StErr,
        StHit
    } state_e;

    state_e            state_q, state_d;
    logic              mem_clk_prev_q;
    logic              req_edge;
    logic              busy;
    logic [17:0]       word_q, word_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;
    logic [23:0]       hi_q, hi_d;
    logic [47:0]       data_q, data_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              overrun_q, overrun_d;
    logic [17:0]       base_sel;
    logic [16:0]       limit_sel;
    logic [17:0]       word_calc;
    logic              addr_bad;
`ifdef SPRITE_SERVER_CACHE_EN
    logic              cache_vld_q, cache_vld_d;
    logic [18:0]       cache_tag_q, cache_tag_d;
    logic              cache_hit;
`endif

    assign req_edge = MEM_CLK && !mem_clk_prev_q;

    // Sprite base and size lookup for the currently presented select.
    always_comb begin
        base_sel  = 18'(BG_BASE);
        limit_sel = 17'(BG_LIMIT);
        case (MEM_SEL)
            3'd0: begin base_sel = 18'(BG_BASE);     limit_sel = 17'(BG_LIMIT);     end
            3'd1: begin base_sel = 18'(PWR_BASE);    limit_sel = 17'(PWR_LIMIT);    end
            3'd2: begin base_sel = 18'(RED_BASE);    limit_sel = 17'(RED_LIMIT);    end
            3'd3: begin base_sel = 18'(GREEN_BASE);  limit_sel = 17'(GREEN_LIMIT);  end
            3'd4: begin base_sel = 18'(BLUE_BASE);   limit_sel = 17'(BLUE_LIMIT);   end
            3'd5: begin base_sel = 18'(YELLOW_BASE); limit_sel = 17'(YELLOW_LIMIT); end
            3'd6: begin base_sel = 18'(WIN_BASE);    limit_sel = 17'(WIN_LIMIT);    end
            default: begin base_sel = 18'(LOSE_BASE); limit_sel = 17'(LOSE_LIMIT); end
        endcase
    end

    assign word_calc = base_sel + {2'b00, MEM_ADDR};
    assign addr_bad  = ({1'b0, MEM_ADDR} >= limit_sel);

`ifdef SPRITE_SERVER_CACHE_EN
    assign cache_hit = cache_vld_q && (cache_tag_q == {MEM_SEL, MEM_ADDR});
`endif

    // ERR is not busy: the request was rejected, so a new edge there is accepted.
    assign busy = (state_q != StIdle) && (state_q != StErr);

    // Next-state logic: request acceptance, ROM sequencing and word assembly.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        lat_cnt_d  = lat_cnt_q;
        hi_d       = hi_q;
        data_d     = data_q;
        rom_addr_d = rom_addr_q;
        overrun_d  = req_edge && busy;
`ifdef SPRITE_SERVER_CACHE_EN
        cache_vld_d = cache_vld_q;
        cache_tag_d = cache_tag_q;
`endif
        case (state_q)
            StIdle, StErr: begin
                state_d = StIdle;
                if (req_edge) begin
                    if (addr_bad) begin
                        state_d = StErr;
                        data_d  = '0;
`ifdef SPRITE_SERVER_CACHE_EN
                        cache_vld_d = 1'b0;
                    end else if (cache_hit) begin
                        state_d = StHit;
`endif
                    end else begin
                        state_d    = StRdHi;
                        word_d     = word_calc;
                        rom_addr_d = ROM_AW'({word_calc, 1'b0});
`ifdef SPRITE_SERVER_CACHE_EN
                        // Entry is being replaced; it becomes valid again at DONE.
                        cache_vld_d = 1'b0;
                        cache_tag_d = {MEM_SEL, MEM_ADDR};
`endif
                    end
                end
            end
            StRdHi: begin
                state_d   = StWtHi;
                lat_cnt_d = '0;
            end
            StWtHi: begin
                if (lat_cnt_q == LatLast) begin
                    hi_d       = ROM_DATA;
                    state_d    = StRdLo;
                    rom_addr_d = ROM_AW'({word_q, 1'b1});
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            StRdLo: begin
                state_d   = StWtLo;
                lat_cnt_d = '0;
            end
            StWtLo: begin
                if (lat_cnt_q == LatLast) begin
                    // Both halves land together so a partial word is never visible.
                    data_d  = {hi_q, ROM_DATA};
                    state_d = StDone;
`ifdef SPRITE_SERVER_CACHE_EN
                    cache_vld_d = 1'b1;
`endif
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            StDone, StHit: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q        <= StIdle;
            mem_clk_prev_q <= 1'b0;
            word_q         <= '0;
            lat_cnt_q      <= '0;
            hi_q           <= '0;
            data_q         <= '0;
            rom_addr_q     <= '0;
            overrun_q      <= 1'b0;
`ifdef SPRITE_SERVER_CACHE_EN
            cache_vld_q    <= 1'b0;
            cache_tag_q    <= '0;
`endif
        end else begin
            state_q        <= state_d;
            mem_clk_prev_q <= MEM_CLK;
            word_q         <= word_d;
            lat_cnt_q      <= lat_cnt_d;
            hi_q           <= hi_d;
            data_q         <= data_d;
            rom_addr_q     <= rom_addr_d;
            overrun_q      <= overrun_d;
`ifdef SPRITE_SERVER_CACHE_EN
            cache_vld_q    <= cache_vld_d;
            cache_tag_q    <= cache_tag_d;
`endif
        end
    end

    assign DATA_OUT   = data_q;
    assign DATA_VALID = (state_q == StDone) || (state_q == StHit);
    assign BUSY       = busy;
    assign ADDR_ERR   = (state_q == StErr);
    assign OVERRUN    = overrun_q;
    assign ROM_RD     = (state_q == StRdHi) || (state_q == StRdLo);
    assign ROM_ADDR   = rom_addr_q;

endmodule

// File: tb/tb_sprite_mem_server.sv
// tb_sprite_mem_server: directed plus random requests against a word-level model
// of the sprite server, with a latency-accurate ROM beside the DUT.
module tb_sprite_mem_server;

    localparam int unsigned L = 1;
    localparam int unsigned BASE [8] = '{0, 64800, 65000, 79112, 93224, 107336, 121448, 143048};
    localparam int unsigned LIMIT[8] = '{64800, 200, 14112, 14112, 14112, 14112, 21600, 25200};

    logic        CLK;
    logic        RESET;
    logic        MEM_CLK;
    logic [15:0] MEM_ADDR;
    logic [2:0]  MEM_SEL;
    logic [47:0] DATA_OUT;
    logic        DATA_VALID;
    logic        BUSY;
    logic        ADDR_ERR;
    logic        OVERRUN;
    logic        ROM_RD;
    logic [18:0] ROM_ADDR;
    logic [23:0] ROM_DATA;

    int total = 0;
    int bad   = 0;

    // Observation counters, written only by the monitor.
    int          dv_cnt = 0;
    int          ov_cnt = 0;
    logic [18:0] rd_q[$];

    // Reference model state.
    logic [47:0] m_last = '0;
    logic        m_vld  = 1'b0;
    logic [18:0] m_tag  = '0;

    sprite_mem_server #(
        .ROM_LAT (L)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .MEM_CLK    (MEM_CLK),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_SEL    (MEM_SEL),
        .DATA_OUT   (DATA_OUT),
        .DATA_VALID (DATA_VALID),
        .BUSY       (BUSY),
        .ADDR_ERR   (ADDR_ERR),
        .OVERRUN    (OVERRUN),
        .ROM_RD     (ROM_RD),
        .ROM_ADDR   (ROM_ADDR),
        .ROM_DATA   (ROM_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [23:0] rom_fn(input logic [18:0] a);
        logic [23:0] x;
        x = {5'd0, a};
        if (a == 19'd0) return 24'h112233;
        if (a == 19'd1) return 24'h445566;
        return (x * 24'h009E37) ^ 24'h5AC3E1;
    endfunction

    // ROM: data valid L cycles after ROM_RD, junk otherwise.
    logic [23:0] rom_pipe [L];
    always @(posedge CLK) begin
        rom_pipe[0] <= ROM_RD ? rom_fn(ROM_ADDR) : 24'($urandom);
        for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign ROM_DATA = rom_pipe[L-1];

    // Monitor: ROM read addresses and pulse counts.
    always @(posedge CLK) begin
        if (ROM_RD) rd_q.push_back(ROM_ADDR);
        if (DATA_VALID) dv_cnt++;
        if (OVERRUN) ov_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request, checked end to end against the model.
    task automatic access(input string tag, input logic [2:0] sel, input logic [15:0] addr,
                          input int hold);
        int unsigned w;
        logic        err, hit;
        logic [47:0] exp_data, got_data;
        int          exp_lat, exp_reads, dv0, ov0, rd0, got, n;
        logic        got_err, busy1, early;
        w   = BASE[sel] + {16'd0, addr};
        err = ({16'd0, addr} >= LIMIT[sel]);
        hit = 1'b0;
`ifdef SPRITE_SERVER_CACHE_EN
        hit = !err && m_vld && (m_tag == {sel, addr});
`endif
        exp_data  = err ? 48'd0 : hit ? m_last : {rom_fn(19'(2*w)), rom_fn(19'(2*w+1))};
        exp_lat   = (err || hit) ? 1 : int'(2*L + 3);
        exp_reads = (err || hit) ? 0 : 2;
        dv0 = dv_cnt; ov0 = ov_cnt; rd0 = rd_q.size();
        got = 0; n = 0; early = 1'b0; busy1 = 1'b0; got_err = 1'b0; got_data = '0;
        @(negedge CLK);
        MEM_SEL = sel; MEM_ADDR = addr; MEM_CLK = 1'b1;
        while (n < 40 && !(got != 0 && n > got && n > hold)) begin
            @(negedge CLK);
            n++;
            if (n >= hold) MEM_CLK = 1'b0;
            if (n == 1) busy1 = BUSY;
            if (got == 0) begin
                if (DATA_VALID || ADDR_ERR) begin
                    got = n; got_data = DATA_OUT; got_err = ADDR_ERR;
                end else if (DATA_OUT !== m_last) begin
                    early = 1'b1;
                end
            end
        end
        check({tag, "/lat"}, got, exp_lat);
        check({tag, "/err"}, got_err, err);
        check({tag, "/data"}, got_data, exp_data);
        check({tag, "/busy1"}, busy1, !err);
        check({tag, "/busy_end"}, BUSY, 0);
        check({tag, "/dv_cnt"}, dv_cnt - dv0, err ? 0 : 1);
        check({tag, "/ov_cnt"}, ov_cnt - ov0, 0);
        check({tag, "/reads"}, rd_q.size() - rd0, exp_reads);
        check({tag, "/early"}, early, 0);
        if (exp_reads == 2 && rd_q.size() - rd0 >= 2) begin
            check({tag, "/addr_hi"}, rd_q[rd0], 19'(2*w));
            check({tag, "/addr_lo"}, rd_q[rd0+1], 19'(2*w + 1));
        end
        if (err) begin
            m_vld = 1'b0; m_last = '0;
        end else if (!hit) begin
            m_last = exp_data; m_vld = 1'b1; m_tag = {sel, addr};
        end
    endtask

    int          dv0, ov0, rd0, got, r, hold;
    logic [47:0] got_data, exp48;
    int unsigned w;
    logic [2:0]  sel, p_sel;
    logic [15:0] addr, p_addr;

    initial begin
        RESET = 1'b1; MEM_CLK = 1'b0; MEM_ADDR = '0; MEM_SEL = '0;
        p_sel = '0; p_addr = '0;
        repeat (3) @(negedge CLK);
        check("rst/dout", DATA_OUT, 0);
        check("rst/dv", DATA_VALID, 0);
        check("rst/busy", BUSY, 0);
        check("rst/err", ADDR_ERR, 0);
        check("rst/ov", OVERRUN, 0);
        check("rst/rd", ROM_RD, 0);
        check("rst/raddr", ROM_ADDR, 0);
        RESET = 1'b0;
        @(negedge CLK);

        // Basic read of the first background word.
        access("t1", 3'd0, 16'd0, 1);
        check("t1/const", DATA_OUT, 48'h112233445566);

        // Last power-up word maps to ROM words 129998/129999; one past is an error.
        access("t2a", 3'd1, 16'd199, 1);
        check("t2a/raddr", ROM_ADDR, 19'd129999);
        access("t2b", 3'd1, 16'd200, 1);

        // Last lose-screen word with MEM_CLK held high for 10 cycles.
        access("t3", 3'd7, 16'd25199, 10);
        check("t3/raddr", ROM_ADDR, 19'd336495);

        // Second edge during an access is dropped and flagged.
        w     = BASE[6] + 32'd100;
        exp48 = {rom_fn(19'(2*w)), rom_fn(19'(2*w+1))};
        dv0 = dv_cnt; ov0 = ov_cnt; rd0 = rd_q.size(); got = 0; got_data = '0;
        @(negedge CLK);
        MEM_SEL = 3'd6; MEM_ADDR = 16'd100; MEM_CLK = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge CLK);
            if (n == 1) MEM_CLK = 1'b0;
            if (n == 2) begin MEM_SEL = 3'd1; MEM_ADDR = 16'd3; MEM_CLK = 1'b1; end
            if (n == 3) MEM_CLK = 1'b0;
            if (got == 0 && DATA_VALID) begin got = n; got_data = DATA_OUT; end
        end
        check("t4/ov_cnt", ov_cnt - ov0, 1);
        check("t4/dv_cnt", dv_cnt - dv0, 1);
        check("t4/lat", got, 2*L + 3);
        check("t4/data", got_data, exp48);
        check("t4/reads", rd_q.size() - rd0, 2);
        m_last = exp48; m_vld = 1'b1; m_tag = {3'd6, 16'd100};

        // Reset while waiting for the low half aborts the access.
        dv0 = dv_cnt;
        @(negedge CLK);
        MEM_SEL = 3'd3; MEM_ADDR = 16'd7; MEM_CLK = 1'b1;
        for (int n = 1; n <= 2*L + 3; n++) begin
            @(negedge CLK);
            if (n == 1) MEM_CLK = 1'b0;
            if (n == 2*L + 2) RESET = 1'b1;
        end
        check("t5/dout", DATA_OUT, 0);
        check("t5/dv", DATA_VALID, 0);
        check("t5/busy", BUSY, 0);
        check("t5/rd", ROM_RD, 0);
        check("t5/raddr", ROM_ADDR, 0);
        check("t5/err", ADDR_ERR, 0);
        check("t5/ov", OVERRUN, 0);
        RESET = 1'b0;
        @(negedge CLK);
        check("t5/dv_cnt", dv_cnt - dv0, 0);
        m_last = '0; m_vld = 1'b0;
        access("t5b", 3'd3, 16'd7, 1);

        // Repeated word (cache hit when the cache is built in), then a neighbour.
        access("t6a", 3'd2, 16'd5, 1);
        access("t6b", 3'd2, 16'd5, 1);
        access("t6c", 3'd2, 16'd6, 2);

        // Random requests biased toward the sprite boundaries and repeats.
        for (int i = 0; i < 24; i++) begin
            r   = int'($urandom_range(0, 4));
            sel = 3'($urandom_range(0, 7));
            case (r)
                0: addr = 16'($urandom);
                1: addr = 16'(LIMIT[sel] - 1);
                2: addr = 16'(LIMIT[sel]);
                3: addr = 16'($urandom_range(0, LIMIT[sel] - 1));
                default: begin sel = p_sel; addr = p_addr; end
            endcase
            hold = int'($urandom_range(1, 3));
            access($sformatf("rand%0d", i), sel, addr, hold);
            p_sel = sel; p_addr = addr;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
